udp_rx_slot_dma: RTL and testbench

Receive-side scheduler placed after the UDP receive parser. It takes the parser's 32-bit payload words, admits or drops whole packets, and buffers admitted words in a word FIFO. It drains the FIFO as bursts into a ring of fixed-size memory slots, then hands one descriptor per packet to software or the consumer logic. Slots return to the ring through an in-order release pulse.

---
 rtl/udp_dma_pkg.sv | 24 ++
 rtl/sync_fifo_w33.sv | 50 +++++
 rtl/udp_rx_slot_dma.sv | 198 +++++++++++++++++++
 tb/tb_udp_rx_slot_dma.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/udp_dma_pkg.sv
// Shared definitions for the UDP receive slot DMA: defaults, write-FSM encoding
// and the slot address helper.
package udp_dma_pkg;

    localparam int unsigned MAX_PKT_WORDS_DEF = 368;
    localparam int unsigned BURST_LEN_DEF     = 16;

    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        CMD  = 4'b0010,
        DATA = 4'b0100,
        DESC = 4'b1000
    } wr_state_e;

    function automatic logic [63:0] slot_addr(
        input logic [63:0] base,
        input int unsigned slot,
        input int unsigned slot_bytes,
        input int unsigned word_off
    );
        return base + 64'(slot) * 64'(slot_bytes) + 64'(word_off) * 64'd4;
    endfunction

endpackage

// File: rtl/sync_fifo_w33.sv
// 33-bit synchronous FIFO with show-ahead output and occupancy count.
module sync_fifo_w33 #(
    parameter int unsigned DEPTH = 512,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [32:0]   din,
    input  logic          pop,
    output logic [32:0]   dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);

    localparam int unsigned PW = AW + 1;

    logic [32:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        do_push, do_pop;

    // Extra pointer MSB separates the full and empty cases.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        count    = wr_ptr_q - rd_ptr_q;
        dout     = mem_q[rd_ptr_q[AW-1:0]];
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/udp_rx_slot_dma.sv
// Receive scheduler: admits whole UDP payloads into a word FIFO, bursts them
// into a ring of memory slots and issues one descriptor per packet.
module udp_rx_slot_dma
    import udp_dma_pkg::*;
#(
    parameter int unsigned       NUM_SLOTS     = 8,
    parameter int unsigned       SLOT_BYTES    = 2048,
    parameter int unsigned       ADDR_W        = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
    parameter int unsigned       FIFO_DEPTH    = 512,
    parameter int unsigned       BURST_LEN     = BURST_LEN_DEF,
    parameter int unsigned       MAX_PKT_WORDS = MAX_PKT_WORDS_DEF,
    localparam int unsigned      SLOT_W        = $clog2(NUM_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rec_en,
    input  logic [31:0]       rec_data,
    input  logic              rec_pkt_done,
    input  logic [15:0]       rec_byte_num,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    output logic              wr_valid,
    output logic [31:0]       wr_data,
    output logic              wr_last,
    input  logic              wr_ready,
    output logic              desc_valid,
    output logic [SLOT_W-1:0] desc_slot,
    output logic [15:0]       desc_len,
    input  logic              desc_ready,
    input  logic              rel_valid,
    output logic [15:0]       drop_cnt,
    output logic [SLOT_W:0]   slots_free
);

    localparam int unsigned FAW = $clog2(FIFO_DEPTH);
    localparam int unsigned BW  = $clog2(BURST_LEN) + 1;
    localparam int unsigned UW  = SLOT_W + 1;
    localparam int unsigned EW  = FAW + 1;

    wr_state_e         state_q, state_d;
    logic              in_pkt_q, in_pkt_d;
    logic              admit_q, admit_d;
    logic [SLOT_W-1:0] in_slot_q, in_slot_d;
    logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
    logic [SLOT_W:0]   used_q, used_d;
    logic [15:0]       drop_cnt_q, drop_cnt_d;
    logic [FAW:0]      pkt_ends_q, pkt_ends_d;
    logic [15:0]       word_off_q, word_off_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [15:0]       slot_len_q [NUM_SLOTS];

    logic              pkt_start, slot_ok, room, admit_now, adm_inc, rel_dec, len_we;
    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    logic              push_last, pop_last;
    logic [32:0]       fifo_din, fifo_dout;
    logic [FAW:0]      fifo_count;

    sync_fifo_w33 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    // Admission is decided once, on the first event of a packet, and held.
    always_comb begin
        pkt_start  = !in_pkt_q && (rec_en || rec_pkt_done);
        slot_ok    = (used_q != UW'(NUM_SLOTS));
        room       = (FIFO_DEPTH - 32'(fifo_count)) >= MAX_PKT_WORDS;
        admit_now  = pkt_start ? (slot_ok && room) : admit_q;
        adm_inc    = pkt_start && slot_ok && room;
        rel_dec    = rel_valid && (used_q != '0);
        fifo_push  = admit_now && (rec_en || rec_pkt_done);
        fifo_din   = {rec_pkt_done, rec_data};
        len_we     = admit_now && rec_pkt_done;
        in_pkt_d   = rec_pkt_done ? 1'b0 : (pkt_start ? 1'b1 : in_pkt_q);
        admit_d    = admit_now;
        in_slot_d  = len_we ? in_slot_q + SLOT_W'(1) : in_slot_q;
        drop_cnt_d = drop_cnt_q;
        if (rec_pkt_done && !admit_now && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;

        unique case ({adm_inc, rel_dec})
            2'b10:   used_d = used_q + UW'(1);
            2'b01:   used_d = used_q - UW'(1);
            default: used_d = used_q;
        endcase

        push_last = fifo_push && !fifo_full && rec_pkt_done;
        pop_last  = fifo_pop && fifo_dout[32];
        unique case ({push_last, pop_last})
            2'b10:   pkt_ends_d = pkt_ends_q + EW'(1);
            2'b01:   pkt_ends_d = pkt_ends_q - EW'(1);
            default: pkt_ends_d = pkt_ends_q;
        endcase

        slots_free = UW'(NUM_SLOTS) - used_q;
        drop_cnt   = drop_cnt_q;
    end

    always_comb begin
        state_d    = state_q;
        wr_slot_d  = wr_slot_q;
        word_off_d = word_off_q;
        beat_d     = beat_q;
        fifo_pop   = 1'b0;
        wr_req     = 1'b0;
        wr_addr    = '0;
        wr_valid   = 1'b0;
        wr_data    = '0;
        wr_last    = 1'b0;
        desc_valid = 1'b0;
        desc_slot  = '0;
        desc_len   = '0;
        unique case (state_q)
            IDLE: begin
                if (32'(fifo_count) >= BURST_LEN || pkt_ends_q != '0) state_d = CMD;
            end
            CMD: begin
                wr_req  = 1'b1;
                wr_addr = ADDR_W'(slot_addr(64'(BASE_ADDR), 32'(wr_slot_q), SLOT_BYTES,
                                            32'(word_off_q)));
                if (wr_ack) begin
                    state_d = DATA;
                    beat_d  = '0;
                end
            end
            DATA: begin
                wr_valid = !fifo_empty;
                wr_data  = wr_valid ? fifo_dout[31:0] : '0;
                wr_last  = wr_valid && (fifo_dout[32] || beat_q == BW'(BURST_LEN - 1));
                if (wr_valid && wr_ready) begin
                    fifo_pop   = 1'b1;
                    word_off_d = word_off_q + 16'd1;
                    beat_d     = beat_q + BW'(1);
                    if (fifo_dout[32]) begin
                        state_d    = DESC;
                        word_off_d = '0;
                    end else if (wr_last) begin
                        state_d = IDLE;
                    end
                end
            end
            DESC: begin
                desc_valid = 1'b1;
                desc_slot  = wr_slot_q;
                desc_len   = slot_len_q[wr_slot_q];
                if (desc_ready) begin
                    wr_slot_d = wr_slot_q + SLOT_W'(1);
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            in_pkt_q   <= 1'b0;
            admit_q    <= 1'b0;
            in_slot_q  <= '0;
            wr_slot_q  <= '0;
            used_q     <= '0;
            drop_cnt_q <= '0;
            pkt_ends_q <= '0;
            word_off_q <= '0;
            beat_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_pkt_q   <= in_pkt_d;
            admit_q    <= admit_d;
            in_slot_q  <= in_slot_d;
            wr_slot_q  <= wr_slot_d;
            used_q     <= used_d;
            drop_cnt_q <= drop_cnt_d;
            pkt_ends_q <= pkt_ends_d;
            word_off_q <= word_off_d;
            beat_q     <= beat_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_SLOTS; i++) slot_len_q[i] <= '0;
        end else if (len_we) begin
            slot_len_q[in_slot_q] <= rec_byte_num;
        end
    end

endmodule

// File: tb/tb_udp_rx_slot_dma.sv
// Directed bench for udp_rx_slot_dma with a packet-level scoreboard model.
module tb_udp_rx_slot_dma;

    localparam int unsigned NUM_SLOTS  = 8;
    localparam int unsigned SLOT_BYTES = 2048;
    localparam int unsigned FIFO_DEPTH = 512;
    localparam int unsigned BURST_LEN  = 16;
    localparam int unsigned MAXW       = 368;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rec_en = 1'b0, rec_pkt_done = 1'b0;
    logic [31:0] rec_data = '0;
    logic [15:0] rec_byte_num = '0;
    logic        wr_req, wr_valid, wr_last, desc_valid;
    logic        wr_ack = 1'b0, wr_ready = 1'b0, desc_ready = 1'b0, rel_valid = 1'b0;
    logic [31:0] wr_addr, wr_data;
    logic [2:0]  desc_slot;
    logic [15:0] desc_len, drop_cnt;
    logic [3:0]  slots_free;

    always #5 clk = ~clk;

    udp_rx_slot_dma #(
        .NUM_SLOTS(NUM_SLOTS), .SLOT_BYTES(SLOT_BYTES), .ADDR_W(32), .BASE_ADDR(32'h0),
        .FIFO_DEPTH(FIFO_DEPTH), .BURST_LEN(BURST_LEN), .MAX_PKT_WORDS(MAXW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rec_en(rec_en), .rec_data(rec_data),
        .rec_pkt_done(rec_pkt_done), .rec_byte_num(rec_byte_num),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
        .desc_valid(desc_valid), .desc_slot(desc_slot), .desc_len(desc_len),
        .desc_ready(desc_ready), .rel_valid(rel_valid),
        .drop_cnt(drop_cnt), .slots_free(slots_free)
    );

    int n_checks = 0, n_fail = 0;

    // Model state: words, slots and lengths of admitted packets not yet retired.
    logic [32:0]  exp_words[$];
    int unsigned  exp_slot[$], exp_len[$];
    int unsigned  burst_q[$], cmd_addr_q[$];
    int unsigned  used_m, in_slot_m, drop_m, pushed_m, popped_m;
    int unsigned  word_off_m, beat_m, cmd_cnt, beat_total;
    int unsigned  last_burst, last_cmd_addr, last_desc_slot, last_desc_len;
    logic [31:0]  last_data;
    logic [32:0]  w;
    bit           ack_en = 1'b1, ready_en = 1'b1, ready_tog = 1'b0, desc_en = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_words.delete(); exp_slot.delete(); exp_len.delete();
        burst_q.delete(); cmd_addr_q.delete();
        used_m = 0; in_slot_m = 0; drop_m = 0; pushed_m = 0; popped_m = 0;
        word_off_m = 0; beat_m = 0; cmd_cnt = 0; beat_total = 0;
    endtask

    initial forever begin
        @(posedge clk); #1;
        wr_ack     = ack_en && wr_req;
        wr_ready   = ready_tog ? ~wr_ready : ready_en;
        desc_ready = desc_en;
    end

    // Compare process: handshakes occur at the next posedge, sampled here.
    always @(negedge clk) if (rst_n) begin
        if (wr_req && wr_ack) begin
            if (exp_slot.size() == 0) check("cmd_unexpected", 1, 0);
            else check("wr_addr", wr_addr, 64'(exp_slot[0] * SLOT_BYTES + 4 * word_off_m));
            cmd_cnt++; beat_m = 0; last_cmd_addr = wr_addr; cmd_addr_q.push_back(wr_addr);
        end
        if (wr_valid && wr_ready) begin
            if (exp_words.size() == 0) check("beat_unexpected", 1, 0);
            else begin
                w = exp_words.pop_front();
                check("wr_data", wr_data, w[31:0]);
                check("wr_last", wr_last, (beat_m == BURST_LEN - 1) || w[32]);
                beat_m++; beat_total++; popped_m++; last_data = wr_data;
                if (w[32] || beat_m == BURST_LEN) begin
                    last_burst = beat_m; burst_q.push_back(beat_m);
                end
                word_off_m = w[32] ? 0 : word_off_m + 1;
            end
        end
        if (desc_valid && desc_ready) begin
            if (exp_len.size() == 0 || exp_slot.size() == 0) check("desc_unexpected", 1, 0);
            else begin
                check("desc_slot", desc_slot, exp_slot[0]);
                check("desc_len", desc_len, exp_len[0]);
                last_desc_slot = exp_slot.pop_front();
                last_desc_len  = exp_len.pop_front();
            end
        end
    end

    task automatic send_pkt(input int unsigned nbytes, input bit resid, input logic [7:0] tag);
        int unsigned nw = (nbytes + 3) / 4;
        bit adm = 1'b0;
        logic [31:0] d;
        for (int unsigned i = 0; i < nw; i++) begin
            @(posedge clk); #1;
            d = {tag, 8'h5A, 16'(i)};
            if (resid && i == nw - 1) d = {tag, 8'hE1, 16'h0000};
            if (i == 0) begin
                adm = (used_m < NUM_SLOTS) && (FIFO_DEPTH - (pushed_m - popped_m) >= MAXW);
                if (adm) begin
                    exp_slot.push_back(in_slot_m);
                    used_m++; in_slot_m = (in_slot_m + 1) % NUM_SLOTS;
                end
            end
            rec_en       = !(resid && i == nw - 1);
            rec_data     = d;
            rec_pkt_done = (i == nw - 1);
            rec_byte_num = (i == nw - 1) ? 16'(nbytes) : 16'h0;
            if (adm) begin
                exp_words.push_back({i == nw - 1, d}); pushed_m++;
            end
            if (i == nw - 1) begin
                if (adm) exp_len.push_back(nbytes);
                else if (drop_m < 65535) drop_m++;
            end
        end
        @(posedge clk); #1;
        rec_en = 1'b0; rec_pkt_done = 1'b0; rec_data = '0; rec_byte_num = '0;
    endtask

    task automatic release_slot();
        @(posedge clk); #1; rel_valid = 1'b1;
        if (used_m > 0) used_m--;
        @(posedge clk); #1; rel_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n = 0;
        while ((exp_words.size() != 0 || exp_len.size() != 0) && n < 20000) begin
            @(negedge clk); n++;
        end
        check({name, "_drain_done"}, n < 20000, 1);
        repeat (4) @(negedge clk);
        check({name, "_slots_free"}, slots_free, NUM_SLOTS - used_m);
        check({name, "_drop_cnt"}, drop_cnt, drop_m);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ctrl"}, {wr_req, wr_valid, wr_last, desc_valid, desc_slot, desc_len, drop_cnt}, 0);
        check({name, "_data"}, {wr_addr, wr_data}, 0);
        check({name, "_slots_free"}, slots_free, 8);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0; rec_en = 1'b0; rec_pkt_done = 1'b0; rel_valid = 1'b0;
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        int unsigned n;
        int unsigned reqs;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset_state");
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;

        // 64-byte packet, last word coincident with done.
        send_pkt(64, 0, 8'h11);
        drain("t1");
        check("t1_cmds", cmd_cnt, 1);
        check("t1_addr", last_cmd_addr, 32'h0);
        check("t1_beats", beat_total, 16);
        check("t1_burst", last_burst, 16);
        check("t1_desc", {last_desc_slot, last_desc_len}, {32'd0, 32'd64});

        // 1000-byte then 30-byte packet back to back.
        apply_reset();
        send_pkt(1000, 0, 8'h21);
        send_pkt(30, 0, 8'h22);
        drain("t2");
        check("t2_cmds", cmd_cnt, 17);
        check("t2_addr1", cmd_addr_q[1], 32'h40);
        check("t2_tail_burst", burst_q[15], 10);
        check("t2_addr2", last_cmd_addr, 32'h800);
        check("t2_burst2", last_burst, 8);
        check("t2_desc2", {last_desc_slot, last_desc_len}, {32'd1, 32'd30});

        // Residual word on a lone done, then single-cycle packets.
        apply_reset();
        send_pkt(30, 1, 8'h33);
        drain("t3a");
        check("t3_beats", beat_total, 8);
        check("t3_resid", last_data, 32'h33E1_0000);
        send_pkt(4, 0, 8'h34);
        drain("t3b");
        check("t3_one_word", {last_desc_slot, last_desc_len, last_burst}, {32'd1, 32'd4, 32'd1});
        send_pkt(2, 1, 8'h44);
        drain("t3c");
        check("t3_lone_done", {last_desc_slot, last_data}, {32'd2, 32'h44E1_0000});

        // Slot exhaustion: 9 packets, 8 slots, no release.
        apply_reset();
        for (int unsigned k = 0; k < 9; k++) send_pkt(8, 0, 8'h50 + 8'(k));
        drain("t4a");
        check("t4_drop", drop_cnt, 1);
        check("t4_full", slots_free, 0);
        release_slot();
        send_pkt(8, 0, 8'h5F);
        drain("t4b");
        check("t4_wrap_slot", last_desc_slot, 0);

        // FIFO room guard: commands stalled, second large packet must drop.
        for (int unsigned k = 0; k < 8; k++) release_slot();
        ack_en = 1'b0;
        send_pkt(800, 0, 8'h61);
        send_pkt(800, 0, 8'h62);
        repeat (2) @(negedge clk);
        check("t5_room_drop", drop_cnt, 2);
        ack_en = 1'b1;
        drain("t5");

        // Backpressure: 50% wr_ready, descriptor held off for 100 cycles.
        apply_reset();
        ready_tog = 1'b1; desc_en = 1'b0;
        send_pkt(100, 0, 8'h71);
        send_pkt(60, 0, 8'h72);
        n = 0;
        while (!desc_valid && n < 2000) begin @(negedge clk); n++; end
        check("t6_desc_seen", n < 2000, 1);
        reqs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (wr_req) reqs++;
        end
        check("t6_no_cmd_while_desc", reqs, 0);
        check("t6_desc_held", {desc_valid, desc_len}, {1'b1, 16'd100});
        desc_en = 1'b1;
        drain("t6");
        ready_tog = 1'b0; ready_en = 1'b1;

        // Reset while a burst is stalled in the data phase.
        apply_reset();
        ready_en = 1'b0;
        send_pkt(64, 0, 8'h81);
        n = 0;
        while (!wr_valid && n < 200) begin @(negedge clk); n++; end
        check("t7_in_data", n < 200, 1);
        rst_n = 1'b0;
        #1 check_reset_outputs("t7_async_reset");
        repeat (3) @(posedge clk);
        model_reset();
        @(negedge clk); rst_n = 1'b1;
        ready_en = 1'b1;
        release_slot();
        @(negedge clk);
        check("t7_rel_when_empty", slots_free, 8);
        send_pkt(64, 0, 8'h82);
        drain("t7");
        check("t7_restart", {last_cmd_addr, last_desc_slot}, {32'h0, 32'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
